// File: rtl/ls191_seq_arbiter.sv
// ls191_seq_arbiter: shares one LS191-style 4-bit up/down counter between
// NREQ requesters. Each grant runs one job: async-load a start value, count
// N steps (optionally stopping at terminal count), then return the count.
module ls191_seq_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_start,
  input  logic [4*NREQ-1:0] req_steps,
  input  logic [NREQ-1:0]   req_dir,
  input  logic [NREQ-1:0]   req_stop_tc,
  output logic              ctr_cten_n,
  output logic              ctr_du,
  output logic              ctr_load_n,
  output logic [3:0]        ctr_d,
  input  logic [3:0]        ctr_q,
  input  logic              ctr_maxmin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_q,
  output logic              rsp_tc
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  last_grant, job_id, win_id, hi_id, lo_id;
  logic [NREQ-1:0] win_oh;
  logic            win_any, hi_hit, lo_hit, tc_hit;
  logic [3:0]      sel_start, sel_steps;
  logic            sel_dir, sel_stop;
  logic [3:0]      job_steps, remaining;
  logic            job_stop;

  // Round-robin pick: lowest valid index above last_grant, else lowest overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > last_grant) begin
          hi_hit = 1'b1;
          hi_id  = IDW'(i);
        end else begin
          lo_hit = 1'b1;
          lo_id  = IDW'(i);
        end
      end
    end
    win_any = hi_hit | lo_hit;
    win_id  = hi_hit ? hi_id : lo_id;
  end

  // Winner one-hot and its request fields, muxed by constant loop index.
  always_comb begin
    win_oh    = '0;
    sel_start = '0;
    sel_steps = '0;
    sel_dir   = 1'b0;
    sel_stop  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_oh[i] = win_any;
        sel_start = req_start[4*i +: 4];
        sel_steps = req_steps[4*i +: 4];
        sel_dir   = req_dir[i];
        sel_stop  = req_stop_tc[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus combinational grant and count-enable outputs.
  // Terminal count is checked before each step, so an early stop never
  // steps past MaxMin.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    ctr_cten_n = 1'b1;
    tc_hit     = job_stop & ctr_maxmin;
    case (state)
      IDLE: begin
        req_ready = win_oh;
        if (win_any) state_nxt = LOAD;
      end
      LOAD: state_nxt = (job_steps == 4'd0) ? DONE : RUN;
      RUN: begin
        ctr_cten_n = tc_hit;
        if (tc_hit || remaining == 4'd1) state_nxt = DONE;
      end
      DONE: if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, counter control and response registers. A normal job
  // captures Q one edge after entering DONE so the final step is visible;
  // an early stop captures immediately since the counter did not move.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NREQ-1);
      job_id     <= '0;
      job_steps  <= '0;
      job_stop   <= 1'b0;
      remaining  <= '0;
      ctr_load_n <= 1'b1;
      ctr_d      <= '0;
      ctr_du     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_q      <= '0;
      rsp_tc     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_any) begin
          last_grant <= win_id;
          job_id     <= win_id;
          job_steps  <= sel_steps;
          job_stop   <= sel_stop;
          ctr_load_n <= 1'b0;
          ctr_d      <= sel_start;
          ctr_du     <= sel_dir;
        end
        LOAD: begin
          ctr_load_n <= 1'b1;
          remaining  <= job_steps;
        end
        RUN: begin
          if (tc_hit) begin
            rsp_valid <= 1'b1;
            rsp_q     <= ctr_q;
            rsp_id    <= job_id;
            rsp_tc    <= 1'b1;
          end else begin
            remaining <= remaining - 4'd1;
          end
        end
        DONE: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_q     <= ctr_q;
            rsp_id    <= job_id;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_tc    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
